// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared state and mode definitions for the bit-serial adder/subtractor
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_fs_cell.sv
// rtl/fa_fs_cell.sv - combinational 1-bit full adder / full subtractor cell
module fa_fs_cell
  import add_sub_pkg::*;
(
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode
);

  // In subtract mode cin/co carry a borrow rather than a carry.
  always_comb begin
    s  = x ^ y ^ cin;
    co = 1'b0;
    case (mode)
      MODE_ADD: co = (x & y) | (cin & (x ^ y));
      MODE_SUB: co = (~x & y) | (cin & ~(x ^ y));
      default:  co = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - LSB-first bit-serial WIDTH-bit adder/subtractor with start/done handshake
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             cy_q, cy_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] acc_shifted;

  fa_fs_cell u_cell (
    .s    (cell_s),
    .co   (cell_co),
    .x    (opa_q[0]),
    .y    (opb_q[0]),
    .cin  (cy_q),
    .mode (mode_q)
  );

  assign acc_shifted = {cell_s, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    cy_d     = cy_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          opa_d   = a;
          opb_d   = b;
          mode_d  = select;
          cy_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        acc_d = acc_shifted;
        cy_d  = cell_co;
        cnt_d = cnt_q + CNT_W'(1);
        // Outputs move only on the last bit so partial sums never leak out.
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          result_d = acc_shifted;
          c_out_d  = cell_co;
          ovf_d    = cy_q ^ cell_co;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      cy_q     <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      cy_q     <= cy_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign c_out  = c_out_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - self-checking bench for serial_add_sub
module tb_serial_add_sub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             select = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .select (select),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       v;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int lat, busy_cnt, overlap, ndone;
  logic [11:0] snap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {c, ovf, result}.
  function automatic logic [9:0] model(input logic s, input logic [7:0] x, input logic [7:0] y);
    int full, sr, sx, sy;
    logic c, v;
    logic [7:0] r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s == 1'b0) begin
      full = int'(x) + int'(y);
      c    = (full > 255);
      sr   = sx + sy;
    end else begin
      full = int'(x) - int'(y);
      c    = (x < y);
      sr   = sx - sy;
    end
    v = (sr > 127) || (sr < -128);
    r = full[7:0];
    return {c, v, r};
  endfunction

  // Starts one operation; optionally pokes start (different operands) or reset in a given RUN cycle.
  task automatic run_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input int poke_cyc, input int rst_cyc);
    @(negedge clk);
    start = 1'b1; select = s; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cnt = 0; overlap = 0; ndone = 0; snap = '1;
    for (int c = 1; c <= WIDTH + 12; c++) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      if (c == rst_cyc + 1) snap = {busy, done, c_out, ovf, result};
      start = (c == poke_cyc);
      if (c == poke_cyc) begin
        a = ~x; b = x; select = ~s;
      end
      rst_n = (c != rst_cyc);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    logic [9:0] m;
    logic [7:0] rx, ry;
    logic rs;
    int k1, k2, dones, unstable;
    logic prev_busy;

    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, c_out, ovf, result}, 12'h000);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, 0, 0);
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
      chk($sformatf("vec%0d_c_out", i), c_out, vecs[i].c);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].v);
      chk($sformatf("vec%0d_done_count", i), ndone, 1);
      chk($sformatf("vec%0d_busy_done_overlap", i), overlap, 0);
      if (i == 0) begin
        chk("done_latency", lat, WIDTH + 1);
        chk("busy_cycles", busy_cnt, WIDTH);
      end
    end

    // start held high: two back-to-back operations
    @(negedge clk);
    start = 1'b1; select = 1'b0; a = 8'hFF; b = 8'h01;
    k1 = -1; k2 = -1; dones = 0; unstable = 0; prev_busy = 1'b0;
    for (int cyc = 0; cyc < 40 && dones < 2; cyc++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        if (k1 < 0) begin
          k1 = cyc; select = 1'b1; a = 8'h10; b = 8'h20;
        end else if (k2 < 0) begin
          k2 = cyc; start = 1'b0;
        end
      end
      if (done) begin
        dones++;
        if (dones == 1) chk("hold_first_result", {c_out, ovf, result}, {2'b10, 8'h00});
        if (dones == 2) chk("hold_second_result", {c_out, ovf, result}, {2'b10, 8'hF0});
      end else if (dones == 1 && result !== 8'h00) begin
        unstable++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    chk("hold_done_count", dones, 2);
    chk("hold_accept_spacing", k2 - k1, WIDTH + 2);
    chk("hold_result_stable", unstable, 0);

    // start poked mid-RUN must be ignored
    run_op(1'b0, 8'h5A, 8'h3C, 3, 0);
    chk("poke_result", {c_out, ovf, result}, {2'b01, 8'h96});
    chk("poke_done_count", ndone, 1);

    // reset in RUN cycle 4 discards the operation
    run_op(1'b0, 8'h33, 8'h44, 0, 4);
    chk("midreset_outputs", snap, 12'h000);
    chk("midreset_no_done", ndone, 0);
    run_op(1'b0, 8'h01, 8'h01, 0, 0);
    chk("after_reset_add", {c_out, ovf, result}, {2'b00, 8'h02});

    // randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      run_op(rs, rx, ry, 0, 0);
      m = model(rs, rx, ry);
      chk($sformatf("rand%0d_%s_%02h_%02h", i, rs ? "sub" : "add", rx, ry),
          {c_out, ovf, result}, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial N-bit adder/subtractor controller. It latches two WIDTH-bit operands and a mode, then walks them LSB-first through a single 1-bit full adder/subtractor cell, one bit per clock. A registered carry/borrow links the bits, and the block collects the sum or difference in a shift register. It sits directly upstream of the 1-bit add/sub cell, supplying its operand bits and carry-in and consuming its sum and carry-out, and presents a start/done handshake to the datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  request; accepted only in IDLE.
- select  in  1  mode, latched with start: 0 = add (a+b), 1 = subtract (a−b).
- a  in  WIDTH  operand A, latched with start.
- b  in  WIDTH  operand B, latched with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result, c_out and ovf are valid from this cycle onward.
- result  out  WIDTH  sum or difference.
- c_out  out  1  final carry-out (add) or borrow-out (sub) of the MSB.
- ovf  out  1  two's-complement signed overflow.

## Operation
- State machine IDLE → RUN → DONE → IDLE. Reset state is IDLE.
- IDLE, start=1:
  - latch a, b and select into shift registers opa, opb and a mode register;
  - clear the carry/borrow register cy to 0;
  - clear bit counter cnt to 0;
  - go to RUN.
- IDLE, start=0: hold.
- RUN, each cycle, the cell gets x=opa[0], y=opb[0], cin=cy, mode.
  - Cell arithmetic: s = x^y^cin.
  - Add: co = (x&y) | (cin&(x^y)).
  - Sub: co = (~x&y) | (cin&~(x^y)).
  - On the edge: opa and opb shift right by 1; s shifts into the MSB of accumulator acc (acc shifts right); cy ← co; cnt ← cnt+1.
  - When the cnt=WIDTH−1 bit is processed:
    - result ← final acc value, including this bit's s;
    - c_out ← co;
    - ovf ← cy (carry into MSB) ^ co;
    - go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- start is ignored in RUN and DONE; it is neither queued nor does it corrupt the operation.
- result, c_out and ovf are updated only at the final-bit edge, so intermediate acc values are never visible. They hold until the next operation completes.
- Width rules:
  - cnt is $clog2(WIDTH) bits wide.
  - result wraps modulo 2^WIDTH.
  - Sub with c_out=1 means a < b unsigned.
- Reset mid-operation, rst_n low at any edge:
  - go to IDLE and discard the operation;
  - busy, done, result, c_out, ovf, cy, cnt, acc, opa, opb all become 0.

## Timing
- Reset values: busy=0, done=0, result=0, c_out=0, ovf=0.
- Start accepted at edge E0 → busy=1 from E0 through E_WIDTH. Bits are processed on edges E1…E_WIDTH.
- done=1 in the cycle after E_WIDTH. Latency from the accepting edge to done is WIDTH+1 cycles. The next start is accepted at E_WIDTH+2 at the earliest.
- Throughput: one operation per WIDTH+2 cycles.
- busy and done are never both 1.
- start held high continuously yields back-to-back operations at the maximum rate. Each new operation uses the a, b and select values present at its own accepting edge.

## Structure
- Shared package add_sub_pkg:
  - state typedef enum {IDLE, RUN, DONE};
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- One sub-module, fa_fs_cell: the combinational 1-bit add/sub cell with the equations above. Ports: s, co, x, y, cin, mode.
- serial_add_sub holds the FSM, counter, operand/accumulator shift registers and the cy register.

## Test plan
- WIDTH=8, add 0x5A+0x3C → result=0x96, c_out=0, ovf=1; done exactly 9 cycles after the accepting edge; busy high for 8 cycles.
- Sub 0x10−0x20 → result=0xF0, c_out=1, ovf=0.
- Sub 0x80−0x01 → result=0x7F, c_out=0, ovf=1.
- Add 0xFF+0x01 → result=0x00, c_out=1, ovf=0. Then start held high for two operations → second accepted exactly 10 cycles after the first, first result stable until the second's done.
- Start pulsed in cycle 3 of RUN with different operands → ignored; original result unchanged; no extra done.
- rst_n low for one edge in cycle 4 of RUN → next cycle all outputs 0, FSM in IDLE, no done; a fresh add 0x01+0x01 then gives 0x02.
